vga_char_mover: RTL and testbench
=================================

Name: vga_char_mover

Overview:
- Frame-synchronous controller that sequences the character-block overlay in the VGA picture path.
- Owns the block origin (char_b_h, char_b_v) and foreground colour that the character picture generator consumes.
- Moves the block in a bouncing path and cycles a 4-entry RGB565 palette on every edge bounce.
- Provides run/pause/single-step/home control. Updates are applied only at frame end, so a visible frame never tears.

Parameters:
H_VALID, 640, active pixels per line
V_VALID, 480, active lines per frame
CHAR_W, 256, block width in pixels
CHAR_H, 88, block height in lines
INIT_X, 192, origin x after reset or home
INIT_Y, 208, origin y after reset or home
STEP_X, 2, pixels moved horizontally per move
STEP_Y, 1, lines moved vertically per move
FRAME_DIV, 1, frame ends per move in RUN (range 1..255)

Ports:
vga_clk  in  1  pixel clock
sys_rst_n  in  1  reset, asynchronous, active-low
pix_x  in  10  current pixel x from the VGA timing block (0x3FF outside the active area)
pix_y  in  10  current pixel y from the VGA timing block (0x3FF outside the active area)
key_run  in  1  one-cycle pulse that toggles RUN/PAUSE
key_step  in  1  one-cycle pulse that requests a single move while in PAUSE
key_home  in  1  one-cycle pulse that requests a return to the initial position
char_b_h  out  10  block origin x
char_b_v  out  10  block origin y
char_color  out  16  RGB565 foreground colour
frame_tick  out  1  one-cycle pulse that marks the frame-end update edge
bounce  out  1  one-cycle pulse, coincident with frame_tick, when a reflection occurred

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; the clock is vga_clk.
- Reset values:
  - char_b_h=INIT_X, char_b_v=INIT_Y, char_color=16'hFEC0.
  - frame_tick=0, bounce=0.
  - dir_x=+, dir_y=+, palette index 0, frame_cnt=0.
  - state IDLE; pending step and home flags cleared.
- Frame-end event (fe):
  - fe is asserted in the first cycle where pix_x==H_VALID-1 and pix_y==V_VALID-1, i.e. the condition is true and was false in the previous cycle.
  - Holding the condition for several cycles gives exactly one fe.
- State machine:
  - IDLE: the first fe goes to RUN and performs no move. This aligns the block to the frame.
  - RUN: key_run goes to PAUSE. Each fe increments frame_cnt; when frame_cnt==FRAME_DIV-1, do a move and clear frame_cnt to 0.
  - PAUSE: key_run goes to RUN with frame_cnt cleared. key_step sets step_pend; the next fe performs one move (FRAME_DIV ignored) and clears step_pend.
  - key_step in IDLE or RUN is ignored.
  - key_run and key_step in the same cycle: key_run wins and the step is dropped.
  - key_run in IDLE is ignored.
- key_home:
  - Sets home_pend in any state; the next fe applies it.
  - Applying it sets origin to INIT_X/INIT_Y, dir to +/+, palette index 0, frame_cnt 0, and clears step_pend.
  - Home takes precedence over a move on the same fe. bounce=0 for that update.
- Move arithmetic uses 11-bit intermediates. H_MAX=H_VALID-CHAR_W and V_MAX=V_VALID-CHAR_H.
  - x, dir +: if char_b_h+STEP_X >= H_MAX, set char_b_h=H_MAX and flip dir_x (bounce); else add STEP_X.
  - x, dir −: if char_b_h <= STEP_X, set char_b_h=0 and flip dir_x (bounce); else subtract STEP_X.
  - y: same rule using STEP_Y, V_MAX and dir_y.
- Palette:
  - Order: 0:FEC0, 1:F800, 2:07E0, 3:001F, then wraps 3→0.
  - The index advances by exactly 1 per move that bounces on either axis; an x and y bounce on the same move (corner) counts once.
- Output timing:
  - Origin, colour and direction update on the clock edge after the fe cycle.
  - frame_tick is high for the one cycle following that edge, on every fe in RUN, PAUSE or IDLE, whether or not a move occurred.
  - bounce is high in that same cycle only if the update reflected.
  - No output changes outside the fe update edge, except by reset.
- Asynchronous reset mid-operation returns to all reset values immediately; pending flags are lost.

Test Plan:
1. Release reset, drive pix to (639,479) once -> IDLE→RUN, frame_tick=1, origin stays 192/208. Second fe -> 194/209, colour FEC0, bounce=0.
2. 96 moves from reset with defaults -> 96th move gives char_b_h=384, dir_x flips, bounce=1, colour F800. Next move gives 382.
3. 184 moves from reset -> char_b_v=392, char_b_h=208, bounce=1, colour 07E0. Move 185 gives v=391, h=206.
4. In RUN: key_run -> PAUSE; 3 fe give no change with frame_tick each. key_step then fe -> exactly one move. key_run+key_step in the same cycle -> RUN, no extra move.
5. At 300/250: key_home, then hold pix at (639,479) for 5 cycles -> single update to 192/208, FEC0, dir +/+, bounce=0, one frame_tick.
6. FRAME_DIV=3 -> moves on fe 3, 6, 9 after IDLE. Assert sys_rst_n low mid-frame -> outputs go to 192/208/FEC0 with no clock edge needed.

Source files
------------

// File: rtl/vga_char_mover.sv
// ---------------------------------------------------------------------------
// vga_char_mover
//
// Frame-synchronous controller for the character-block overlay. It holds the
// block origin and foreground colour used by the character picture generator.
// The block bounces around the active area, and the colour steps through a
// 4-entry RGB565 palette on every move that reflects. All visible state
// changes only on the clock edge after a frame-end event, so a displayed
// frame never tears.
//
// Ports:
//   vga_clk     in   pixel clock
//   sys_rst_n   in   asynchronous active-low reset
//   pix_x/pix_y in   current pixel position (0x3FF outside the active area)
//   key_run     in   pulse, toggles RUN/PAUSE
//   key_step    in   pulse, single move request while paused
//   key_home    in   pulse, return to the initial position at the next frame end
//   char_b_h/v  out  block origin x/y
//   char_color  out  RGB565 foreground colour
//   frame_tick  out  one-cycle pulse after every frame-end update edge
//   bounce      out  one-cycle pulse with frame_tick when the update reflected
// ---------------------------------------------------------------------------
module vga_char_mover #(
  parameter int H_VALID   = 640,
  parameter int V_VALID   = 480,
  parameter int CHAR_W    = 256,
  parameter int CHAR_H    = 88,
  parameter int INIT_X    = 192,
  parameter int INIT_Y    = 208,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        key_run,
  input  logic        key_step,
  input  logic        key_home,
  output logic [9:0]  char_b_h,
  output logic [9:0]  char_b_v,
  output logic [15:0] char_color,
  output logic        frame_tick,
  output logic        bounce
);

  localparam logic [10:0] H_MAX    = 11'(H_VALID - CHAR_W);
  localparam logic [10:0] V_MAX    = 11'(V_VALID - CHAR_H);
  localparam logic [10:0] STEP_X_W = 11'(STEP_X);
  localparam logic [10:0] STEP_Y_W = 11'(STEP_Y);
  localparam logic [9:0]  HOME_X   = 10'(INIT_X);
  localparam logic [9:0]  HOME_Y   = 10'(INIT_Y);
  localparam logic [9:0]  LAST_X   = 10'(H_VALID - 1);
  localparam logic [9:0]  LAST_Y   = 10'(V_VALID - 1);
  localparam logic [7:0]  CNT_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        fe_cond_q;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        step_pend_q, step_pend_d;
  logic        home_pend_q, home_pend_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        dir_x_q, dir_x_d;   // 1 = moving toward larger coordinates
  logic        dir_y_q, dir_y_d;
  logic [1:0]  pal_idx_q, pal_idx_d;
  logic        tick_q, tick_d;
  logic        bounce_q, bounce_d;

  logic        fe_cond;
  logic        fe;
  logic [10:0] sum_x, sum_y;
  logic [9:0]  nx, ny;
  logic        bx, by;
  logic        do_move;

  // Frame end is the rising edge of "last active pixel"; a timing block that
  // lingers on that pixel still produces a single event.
  assign fe_cond = (pix_x == LAST_X) && (pix_y == LAST_Y);
  assign fe      = fe_cond && !fe_cond_q;

  // Candidate position for a move, computed in 11 bits so the upper bound
  // test cannot wrap.
  always_comb begin
    sum_x = {1'b0, h_q} + STEP_X_W;
    sum_y = {1'b0, v_q} + STEP_Y_W;
    nx    = h_q;
    ny    = v_q;
    bx    = 1'b0;
    by    = 1'b0;
    if (dir_x_q) begin
      if (sum_x >= H_MAX) begin
        nx = H_MAX[9:0];
        bx = 1'b1;
      end else begin
        nx = sum_x[9:0];
      end
    end else begin
      if ({1'b0, h_q} <= STEP_X_W) begin
        nx = 10'd0;
        bx = 1'b1;
      end else begin
        nx = 10'({1'b0, h_q} - STEP_X_W);
      end
    end
    if (dir_y_q) begin
      if (sum_y >= V_MAX) begin
        ny = V_MAX[9:0];
        by = 1'b1;
      end else begin
        ny = sum_y[9:0];
      end
    end else begin
      if ({1'b0, v_q} <= STEP_Y_W) begin
        ny = 10'd0;
        by = 1'b1;
      end else begin
        ny = 10'({1'b0, v_q} - STEP_Y_W);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    step_pend_d = step_pend_q;
    home_pend_d = home_pend_q;
    h_d         = h_q;
    v_d         = v_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    pal_idx_d   = pal_idx_q;
    tick_d      = 1'b0;
    bounce_d    = 1'b0;
    do_move     = 1'b0;

    if (fe) begin
      tick_d = 1'b1;
      // The first frame end only aligns the controller to the frame.
      if (state_q == IDLE) state_d = RUN;

      if (home_pend_q) begin
        h_d         = HOME_X;
        v_d         = HOME_Y;
        dir_x_d     = 1'b1;
        dir_y_d     = 1'b1;
        pal_idx_d   = 2'd0;
        frame_cnt_d = 8'd0;
        step_pend_d = 1'b0;
        home_pend_d = 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (frame_cnt_q == CNT_LAST) begin
              do_move     = 1'b1;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
          PAUSE: begin
            if (step_pend_q) begin
              do_move     = 1'b1;
              step_pend_d = 1'b0;
            end
          end
          default: ;
        endcase

        if (do_move) begin
          h_d      = nx;
          v_d      = ny;
          dir_x_d  = bx ? !dir_x_q : dir_x_q;
          dir_y_d  = by ? !dir_y_q : dir_y_q;
          bounce_d = bx || by;
          // A corner reflects on both axes but advances the palette once.
          if (bx || by) pal_idx_d = pal_idx_q + 2'd1;
        end
      end
    end

    if (key_home) home_pend_d = 1'b1;

    case (state_q)
      RUN: begin
        if (key_run) state_d = PAUSE;
      end
      PAUSE: begin
        // key_run has priority; a simultaneous step request is dropped.
        if (key_run) begin
          state_d     = RUN;
          frame_cnt_d = 8'd0;
        end else if (key_step) begin
          step_pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      fe_cond_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      step_pend_q <= 1'b0;
      home_pend_q <= 1'b0;
      h_q         <= HOME_X;
      v_q         <= HOME_Y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      pal_idx_q   <= 2'd0;
      tick_q      <= 1'b0;
      bounce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fe_cond_q   <= fe_cond;
      frame_cnt_q <= frame_cnt_d;
      step_pend_q <= step_pend_d;
      home_pend_q <= home_pend_d;
      h_q         <= h_d;
      v_q         <= v_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      pal_idx_q   <= pal_idx_d;
      tick_q      <= tick_d;
      bounce_q    <= bounce_d;
    end
  end

  always_comb begin
    case (pal_idx_q)
      2'd0:    char_color = 16'hFEC0;
      2'd1:    char_color = 16'hF800;
      2'd2:    char_color = 16'h07E0;
      default: char_color = 16'h001F;
    endcase
  end

  assign char_b_h   = h_q;
  assign char_b_v   = v_q;
  assign frame_tick = tick_q;
  assign bounce     = bounce_q;

endmodule

// File: tb/tb_vga_char_mover.sv
// ---------------------------------------------------------------------------
// tb_vga_char_mover
//
// Scoreboard bench. A behavioural model of the mover predicts the origin,
// colour and bounce flag for every frame end it drives and queues the
// prediction; a monitor pops one entry per frame_tick and compares. A second
// instance with FRAME_DIV=3 checks the frame divider and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_vga_char_mover;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [15:0] c;
    logic        b;
  } exp_t;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x = 10'h3FF, pix_y = 10'h3FF;
  logic [9:0]  pix3_x = 10'h3FF, pix3_y = 10'h3FF;
  logic        key_run = 1'b0, key_step = 1'b0, key_home = 1'b0;
  logic        key_zero = 1'b0;

  logic [9:0]  h1, v1, h3, v3;
  logic [15:0] c1, c3;
  logic        t1, b1, t3, b3;

  int checks = 0;
  int errors = 0;

  exp_t sb1[$];
  exp_t sb3[$];

  // model state for the FRAME_DIV=1 instance: 0 IDLE, 1 RUN, 2 PAUSE
  int m_state, m_h, m_v, m_idx, moves;
  bit m_dx, m_dy, m_step, m_home;

  always #5 vga_clk = ~vga_clk;

  vga_char_mover #(.FRAME_DIV(1)) dut1 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .pix_x(pix_x), .pix_y(pix_y),
    .key_run(key_run), .key_step(key_step), .key_home(key_home),
    .char_b_h(h1), .char_b_v(v1), .char_color(c1),
    .frame_tick(t1), .bounce(b1)
  );

  vga_char_mover #(.FRAME_DIV(3)) dut3 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .pix_x(pix3_x), .pix_y(pix3_y),
    .key_run(key_zero), .key_step(key_zero), .key_home(key_zero),
    .char_b_h(h3), .char_b_v(v3), .char_color(c3),
    .frame_tick(t3), .bounce(b3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pal(input int i);
    case (i)
      0:       return 16'hFEC0;
      1:       return 16'hF800;
      2:       return 16'h07E0;
      default: return 16'h001F;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_h = 192; m_v = 208; m_idx = 0; moves = 0;
    m_dx = 1; m_dy = 1; m_step = 0; m_home = 0;
  endtask

  // One frame end as seen by the FRAME_DIV=1 model; queues the prediction.
  task automatic model_fe();
    bit b, mv;
    exp_t e;
    b = 0; mv = 0;
    if (m_home) begin
      m_h = 192; m_v = 208; m_dx = 1; m_dy = 1; m_idx = 0;
      m_step = 0; m_home = 0;
    end else if (m_state == 1) begin
      mv = 1;
    end else if (m_state == 2 && m_step) begin
      mv = 1; m_step = 0;
    end
    if (mv) begin
      moves++;
      if (m_dx) begin
        if (m_h + 2 >= 384) begin m_h = 384; m_dx = 0; b = 1; end
        else m_h = m_h + 2;
      end else begin
        if (m_h <= 2) begin m_h = 0; m_dx = 1; b = 1; end
        else m_h = m_h - 2;
      end
      if (m_dy) begin
        if (m_v + 1 >= 392) begin m_v = 392; m_dy = 0; b = 1; end
        else m_v = m_v + 1;
      end else begin
        if (m_v <= 1) begin m_v = 0; m_dy = 1; b = 1; end
        else m_v = m_v - 1;
      end
      if (b) m_idx = (m_idx + 1) % 4;
    end
    if (m_state == 0) m_state = 1;
    e.h = 10'(m_h); e.v = 10'(m_v); e.c = pal(m_idx); e.b = b;
    sb1.push_back(e);
  endtask

  task automatic do_fe(input int hold);
    model_fe();
    @(posedge vga_clk); #1;
    pix_x = 10'd639; pix_y = 10'd479;
    repeat (hold) @(posedge vga_clk);
    #1;
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    repeat (2) @(posedge vga_clk);
    #1;
  endtask

  task automatic do_fe3();
    @(posedge vga_clk); #1;
    pix3_x = 10'd639; pix3_y = 10'd479;
    @(posedge vga_clk); #1;
    pix3_x = 10'h3FF; pix3_y = 10'h3FF;
    repeat (2) @(posedge vga_clk);
    #1;
  endtask

  task automatic press(input bit r, input bit s, input bit hm);
    @(posedge vga_clk); #1;
    key_run = r; key_step = s; key_home = hm;
    if (hm) m_home = 1;
    if (m_state == 1) begin
      if (r) m_state = 2;
    end else if (m_state == 2) begin
      if (r) m_state = 1;
      else if (s) m_step = 1;
    end
    @(posedge vga_clk); #1;
    key_run = 0; key_step = 0; key_home = 0;
  endtask

  always @(negedge vga_clk) begin
    if (sys_rst_n && t1) begin
      if (sb1.size() == 0) chk("tick1_spurious", 32'(t1), 32'd0);
      else begin
        exp_t e;
        e = sb1.pop_front();
        chk("sb1_h", 32'(h1), 32'(e.h));
        chk("sb1_v", 32'(v1), 32'(e.v));
        chk("sb1_color", 32'(c1), 32'(e.c));
        chk("sb1_bounce", 32'(b1), 32'(e.b));
      end
    end
    if (sys_rst_n && t3) begin
      if (sb3.size() == 0) chk("tick3_spurious", 32'(t3), 32'd0);
      else begin
        exp_t e;
        e = sb3.pop_front();
        chk("sb3_h", 32'(h3), 32'(e.h));
        chk("sb3_v", 32'(v3), 32'(e.v));
        chk("sb3_color", 32'(c3), 32'(e.c));
        chk("sb3_bounce", 32'(b3), 32'(e.b));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_h", 32'(h1), 32'd192);
    chk("rst_v", 32'(v1), 32'd208);
    chk("rst_color", 32'(c1), 32'hFEC0);
    chk("rst_tick", 32'(t1), 32'd0);
    chk("rst_bounce", 32'(b1), 32'd0);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;

    // IDLE -> RUN without a move, then the first move
    do_fe(1);
    chk("idle_fe_h", 32'(h1), 32'd192);
    do_fe(1);
    chk("move1_h", 32'(h1), 32'd194);
    chk("move1_v", 32'(v1), 32'd209);

    // right-edge reflection on move 96
    for (int i = 0; i < 200 && moves < 96; i++) do_fe(1);
    chk("m96_h", 32'(h1), 32'd384);
    chk("m96_color", 32'(c1), 32'hF800);
    do_fe(1);
    chk("m97_h", 32'(h1), 32'd382);

    // bottom-edge reflection on move 184
    for (int i = 0; i < 200 && moves < 184; i++) do_fe(1);
    chk("m184_v", 32'(v1), 32'd392);
    chk("m184_h", 32'(h1), 32'd208);
    chk("m184_color", 32'(c1), 32'h07E0);
    do_fe(1);
    chk("m185_v", 32'(v1), 32'd391);
    chk("m185_h", 32'(h1), 32'd206);

    // pause, single step, run+step together
    press(1, 0, 0);
    repeat (3) do_fe(1);
    chk("pause_h", 32'(h1), 32'd206);
    press(0, 1, 0);
    do_fe(1);
    chk("step_h", 32'(h1), 32'd204);
    do_fe(1);
    chk("step_once_h", 32'(h1), 32'd204);
    press(1, 1, 0);
    do_fe(1);
    chk("resume_h", 32'(h1), 32'd202);

    // home with the frame-end condition held for several cycles
    repeat (20) do_fe(1);
    press(0, 0, 1);
    do_fe(5);
    chk("home_h", 32'(h1), 32'd192);
    chk("home_v", 32'(v1), 32'd208);
    chk("home_color", 32'(c1), 32'hFEC0);
    do_fe(1);
    chk("home_dir_h", 32'(h1), 32'd194);
    chk("home_dir_v", 32'(v1), 32'd209);

    // long run through left-edge and top-edge reflections
    repeat (420) do_fe(1);
    repeat (4) @(posedge vga_clk);
    chk("sb1_drain", 32'(sb1.size()), 32'd0);

    // FRAME_DIV=3 instance
    @(negedge vga_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.h = 10'(192 + 2 * (k / 3));
      e.v = 10'(208 + (k / 3));
      e.c = 16'hFEC0;
      e.b = 1'b0;
      sb3.push_back(e);
      do_fe3();
    end
    chk("div3_h", 32'(h3), 32'd198);
    chk("div3_v", 32'(v3), 32'd211);
    repeat (4) @(posedge vga_clk);
    chk("sb3_drain", 32'(sb3.size()), 32'd0);

    // asynchronous reset between clock edges
    @(posedge vga_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("async_h", 32'(h3), 32'd192);
    chk("async_v", 32'(v3), 32'd208);
    chk("async_color", 32'(c3), 32'hFEC0);
    repeat (2) @(posedge vga_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
